// File: rtl/gameover_sprite_fetch.sv
// gameover_sprite_fetch
//
// Read-side sequencer for the game-over sprite ROM. A START walks one sprite
// row by row, byte by byte, issuing ROM reads and serialising each returned
// byte LSB-first as a 1-bit-per-pixel valid/ready stream for the frame-buffer
// writer.
//
// Optional feature macro: GAMEOVER_FETCH_PREFETCH_EN
//   Adds a one-byte prefetch buffer so consecutive bytes stream without the
//   REQ/WAIT bubble. Undefined: 10 cycles per byte with PIX_READY held high.
//
// Ports:
//   CLOCK_50      in   clock, rising edge
//   RESET         in   asynchronous active-low reset
//   START         in   begin fetch (sampled in IDLE only)
//   SPRITE_SEL    in   sprite index, latched with START
//   ABORT         in   cancel fetch in progress, no DONE
//   R_G_O         out  ROM read enable
//   SPRITE_ID/X/Y out  ROM address (zero when R_G_O is low)
//   SPRITE_PIXEL  in   ROM data, valid the cycle after R_G_O
//   PIX_VALID     out  stream valid
//   PIX_READY     in   stream ready
//   PIX_ON        out  pixel value
//   PIX_COL/ROW   out  pixel position
//   PIX_LAST      out  final pixel of sprite
//   BUSY          out  fetch in progress
//   DONE          out  one-cycle completion pulse
module gameover_sprite_fetch #(
    parameter int unsigned ROWS          = 32,
    parameter int unsigned BYTES_PER_ROW = 32
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic [2:0] SPRITE_SEL,
    input  logic       ABORT,
    output logic       R_G_O,
    output logic [2:0] SPRITE_ID,
    output logic [4:0] SPRITE_X,
    output logic [4:0] SPRITE_Y,
    input  logic [7:0] SPRITE_PIXEL,
    output logic       PIX_VALID,
    input  logic       PIX_READY,
    output logic       PIX_ON,
    output logic [7:0] PIX_COL,
    output logic [4:0] PIX_ROW,
    output logic       PIX_LAST,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [4:0] XLast = 5'(BYTES_PER_ROW - 1);
    localparam logic [4:0] YLast = 5'(ROWS - 1);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StShift, StFin} state_e;

    state_e     state_q, state_d;
    logic [2:0] id_q, id_d;
    logic [4:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;

`ifdef GAMEOVER_FETCH_PREFETCH_EN
    logic [7:0] buf_q, buf_d;
    logic       buf_valid_q, buf_valid_d;
    // A prefetch read was issued last cycle; its data is on SPRITE_PIXEL now.
    logic       pend_q, pend_d;
`endif

    logic       x_wrap, last_byte;
    logic [4:0] next_x, next_y;
    logic       rom_req, busy, done, pix_valid;
    logic [4:0] addr_x, addr_y;

    assign x_wrap    = (x_q == XLast);
    assign last_byte = x_wrap && (y_q == YLast);
    assign next_x    = x_wrap ? 5'd0 : x_q + 5'd1;
    assign next_y    = x_wrap ? y_q + 5'd1 : y_q;
    assign pix_valid = (state_q == StShift);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rom_req = 1'b0;
        addr_x  = x_q;
        addr_y  = y_q;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef GAMEOVER_FETCH_PREFETCH_EN
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        pend_d      = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    id_d    = SPRITE_SEL;
                    x_d     = 5'd0;
                    y_d     = 5'd0;
                    bit_d   = 3'd0;
                    state_d = StReq;
                end
            end
            StReq: begin
                rom_req = 1'b1;
                busy    = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                busy    = 1'b1;
                shift_d = SPRITE_PIXEL;
                state_d = StShift;
            end
            StShift: begin
                busy = 1'b1;
`ifdef GAMEOVER_FETCH_PREFETCH_EN
                if (pend_q) begin
                    buf_d       = SPRITE_PIXEL;
                    buf_valid_d = 1'b1;
                end
                // Prefetch only on a ready cycle so a stalled stream never reads the ROM.
                if (!buf_valid_q && !pend_q && !last_byte && PIX_READY) begin
                    rom_req = 1'b1;
                    addr_x  = next_x;
                    addr_y  = next_y;
                    pend_d  = 1'b1;
                end
`endif
                if (PIX_READY) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (last_byte) begin
                            state_d = StFin;
                        end else begin
                            x_d = next_x;
                            y_d = next_y;
`ifdef GAMEOVER_FETCH_PREFETCH_EN
                            if (buf_valid_q) begin
                                shift_d     = buf_q;
                                buf_valid_d = 1'b0;
                            end else begin
                                // Buffer not ready: fall back to a plain read.
                                state_d     = StReq;
                                buf_valid_d = 1'b0;
                                pend_d      = 1'b0;
                            end
`else
                            state_d = StReq;
`endif
                        end
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (ABORT && (state_q != StIdle)) begin
            state_d = StIdle;
            id_d    = 3'd0;
            x_d     = 5'd0;
            y_d     = 5'd0;
            bit_d   = 3'd0;
            shift_d = 8'd0;
            done    = 1'b0;
`ifdef GAMEOVER_FETCH_PREFETCH_EN
            buf_d       = 8'd0;
            buf_valid_d = 1'b0;
            pend_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            id_q    <= 3'd0;
            x_q     <= 5'd0;
            y_q     <= 5'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

`ifdef GAMEOVER_FETCH_PREFETCH_EN
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            buf_q       <= 8'd0;
            buf_valid_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            pend_q      <= pend_d;
        end
    end
`endif

    // Address and pixel fields are forced to zero when not qualified so the
    // idle bus reads all-zero.
    assign R_G_O     = rom_req;
    assign SPRITE_ID = rom_req ? id_q : 3'd0;
    assign SPRITE_X  = rom_req ? addr_x : 5'd0;
    assign SPRITE_Y  = rom_req ? addr_y : 5'd0;
    assign PIX_VALID = pix_valid;
    assign PIX_ON    = pix_valid & shift_q[0];
    assign PIX_COL   = pix_valid ? {x_q, bit_q} : 8'd0;
    assign PIX_ROW   = pix_valid ? y_q : 5'd0;
    assign PIX_LAST  = pix_valid && last_byte && (bit_q == 3'd7);
    assign BUSY      = busy;
    assign DONE      = done;

endmodule

// File: tb/tb_gameover_sprite_fetch.sv
// Testbench for gameover_sprite_fetch: directed sequence with a registered
// ROM model and a pixel-stream reference built from the ROM contents.
module tb_gameover_sprite_fetch;

    logic       CLOCK_50;
    logic       RESET;
    logic       START;
    logic [2:0] SPRITE_SEL;
    logic       ABORT;
    logic       R_G_O;
    logic [2:0] SPRITE_ID;
    logic [4:0] SPRITE_X;
    logic [4:0] SPRITE_Y;
    logic [7:0] SPRITE_PIXEL;
    logic       PIX_VALID;
    logic       PIX_READY;
    logic       PIX_ON;
    logic [7:0] PIX_COL;
    logic [4:0] PIX_ROW;
    logic       PIX_LAST;
    logic       BUSY;
    logic       DONE;

`ifdef GAMEOVER_FETCH_PREFETCH_EN
    localparam int ExpDone = 8195;
`else
    localparam int ExpDone = 10241;
`endif

    int n_checks;
    int n_fail;

    // Stream statistics filled by stream().
    int         hs, pix_err, last_cnt, last_err, busy_err, rgo_pairs, gaps;
    int         stall_err, stall_rgo, stall_hs, done_cyc;
    logic [7:0] stall_bits;
    logic       stopped;

    gameover_sprite_fetch dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .START       (START),
        .SPRITE_SEL  (SPRITE_SEL),
        .ABORT       (ABORT),
        .R_G_O       (R_G_O),
        .SPRITE_ID   (SPRITE_ID),
        .SPRITE_X    (SPRITE_X),
        .SPRITE_Y    (SPRITE_Y),
        .SPRITE_PIXEL(SPRITE_PIXEL),
        .PIX_VALID   (PIX_VALID),
        .PIX_READY   (PIX_READY),
        .PIX_ON      (PIX_ON),
        .PIX_COL     (PIX_COL),
        .PIX_ROW     (PIX_ROW),
        .PIX_LAST    (PIX_LAST),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] rom_byte(input logic [2:0] id, input logic [4:0] x,
                                            input logic [4:0] y);
        if (id == 3'd2 && x == 5'd0 && y == 5'd0) return 8'hA5;
        if (x == 5'd3 && y == 5'd4) return 8'h3C;
        return ({3'b0, x} * 8'd7 + {3'b0, y} * 8'd13 + {5'b0, id} * 8'd29) ^ 8'h5A;
    endfunction

    // ROM answers one cycle after the read enable.
    initial SPRITE_PIXEL = 8'd0;
    always @(posedge CLOCK_50) begin
        if (R_G_O) SPRITE_PIXEL <= rom_byte(SPRITE_ID, SPRITE_X, SPRITE_Y);
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {R_G_O, SPRITE_ID, SPRITE_X, SPRITE_Y, PIX_VALID, PIX_ON, PIX_COL,
                    PIX_ROW, PIX_LAST, BUSY, DONE}, 32'd0);
    endtask

    // Drive START for one edge; returns sampling cycle 1.
    task automatic start_fetch(input logic [2:0] sel);
        SPRITE_SEL = sel;
        START      = 1'b1;
        tick();
        START      = 1'b0;
    endtask

    // Follow a fetch from cycle 1 until DONE (or stop point), checking every
    // handshaken pixel against the ROM contents.
    task automatic stream(input logic [2:0] sel, input bit stall_mode, input bit stop_mid);
        logic       prev_rgo, prev_stall, seen_valid, prev_on;
        logic [7:0] prev_col, rb;
        logic [4:0] prev_row;
        logic [3:0] ready_pat;
        int         k;
        hs = 0; pix_err = 0; last_cnt = 0; last_err = 0; busy_err = 0; rgo_pairs = 0;
        gaps = 0; stall_err = 0; stall_rgo = 0; stall_hs = 0; stall_bits = 8'd0;
        done_cyc = -1; stopped = 1'b0;
        prev_rgo = 1'b0; prev_stall = 1'b0; seen_valid = 1'b0; prev_on = 1'b0;
        prev_col = 8'd0; prev_row = 5'd0; ready_pat = 4'b1001; k = 0;
        for (int c = 1; c <= 12000; c++) begin
            PIX_READY = 1'b1;
            if (stall_mode && PIX_VALID && PIX_ROW == 5'd4 && PIX_COL[7:3] == 5'd3) begin
                PIX_READY = ready_pat[k % 4];
                k++;
            end
            if (stop_mid && PIX_VALID && PIX_ROW == 5'd10 && PIX_COL == 8'd40) begin
                PIX_READY = 1'b0;
                stopped   = 1'b1;
                break;
            end
            #1;
            if (DONE) begin
                done_cyc = c;
                break;
            end
            if (!BUSY) busy_err++;
            if (R_G_O && prev_rgo) rgo_pairs++;
            if (seen_valid && !PIX_VALID) gaps++;
            if (PIX_VALID) seen_valid = 1'b1;
            if (prev_stall && ({PIX_ON, PIX_COL, PIX_ROW} !== {prev_on, prev_col, prev_row}))
                stall_err++;
            if (!PIX_READY && R_G_O) stall_rgo++;
            if (PIX_LAST && !PIX_VALID) last_err++;
            if (PIX_VALID && PIX_READY) begin
                rb = rom_byte(sel, hs[7:3], hs[12:8]);
                if ({PIX_ON, PIX_COL, PIX_ROW} !== {rb[hs[2:0]], hs[7:0], hs[12:8]}) pix_err++;
                if (PIX_LAST !== (hs == 8191)) last_err++;
                if (PIX_LAST) last_cnt++;
                if (stall_mode && PIX_ROW == 5'd4 && PIX_COL[7:3] == 5'd3) begin
                    stall_bits[PIX_COL[2:0]] = PIX_ON;
                    stall_hs++;
                end
                hs++;
            end
            prev_stall = PIX_VALID && !PIX_READY;
            prev_on    = PIX_ON;
            prev_col   = PIX_COL;
            prev_row   = PIX_ROW;
            prev_rgo   = R_G_O;
            tick();
        end
    endtask

    initial begin
        int a5_exp[8];
        int done_seen;
        bit found;
        a5_exp = '{1, 0, 1, 0, 0, 1, 0, 1};
        n_checks = 0;
        n_fail   = 0;
        RESET = 1'b1; START = 1'b0; SPRITE_SEL = 3'd0; ABORT = 1'b0; PIX_READY = 1'b1;
        #1 RESET = 1'b0;
        repeat (3) tick();
        check_idle("reset_outputs");
        RESET = 1'b1;
        tick();
        check_idle("post_reset_idle");

        // First byte of sprite 2 (0xA5).
        start_fetch(3'd2);
        check("a5_req_rgo", 32'(R_G_O), 1);
        check("a5_req_id", 32'(SPRITE_ID), 2);
        check("a5_req_x", 32'(SPRITE_X), 0);
        check("a5_req_y", 32'(SPRITE_Y), 0);
        check("a5_req_busy", 32'(BUSY), 1);
        tick();
        check("a5_wait_rgo", 32'(R_G_O), 0);
        check("a5_wait_valid", 32'(PIX_VALID), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("a5_valid%0d", i), 32'(PIX_VALID), 1);
            check($sformatf("a5_on%0d", i), 32'(PIX_ON), 32'(a5_exp[i]));
            check($sformatf("a5_col%0d", i), 32'(PIX_COL), 32'(i));
            check($sformatf("a5_row%0d", i), 32'(PIX_ROW), 0);
        end

        // Continue to pixel 100, then abort.
        hs    = 8;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (PIX_VALID) begin
                if (hs == 100) begin
                    found = 1'b1;
                    break;
                end
                hs++;
            end
        end
        check("abort_reached", 32'(found), 1);
        check("abort_col", 32'(PIX_COL), 100);
        check("abort_row", 32'(PIX_ROW), 0);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check_idle("abort_idle");
        done_seen = 0;
        repeat (5) begin
            tick();
            if (DONE) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 0);

        // Restart after abort begins at X=0,Y=0; abort in WAIT discards the read.
        start_fetch(3'd1);
        check("restart_rgo", 32'(R_G_O), 1);
        check("restart_id", 32'(SPRITE_ID), 1);
        check("restart_x", 32'(SPRITE_X), 0);
        check("restart_y", 32'(SPRITE_Y), 0);
        tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check_idle("abort_wait_idle");
        tick();
        check_idle("abort_wait_discard");

        // Full sprite 7 with READY held high.
        start_fetch(3'd7);
        stream(3'd7, 1'b0, 1'b0);
        check("full7_handshakes", 32'(hs), 8192);
        check("full7_pixels", 32'(pix_err), 0);
        check("full7_last_count", 32'(last_cnt), 1);
        check("full7_last_pos", 32'(last_err), 0);
        check("full7_busy", 32'(busy_err), 0);
        check("full7_rgo_pairs", 32'(rgo_pairs), 0);
        check("full7_done_cycle", 32'(done_cyc), 32'(ExpDone));
        check("full7_done_busy", 32'(BUSY), 0);
`ifdef GAMEOVER_FETCH_PREFETCH_EN
        check("full7_valid_gaps", 32'(gaps), 0);
`endif
        tick();
        check_idle("full7_after_done");

        // Sprite 5: stall pattern on byte 0x3C (row 4, byte 3), then reset mid row 10.
        start_fetch(3'd5);
        stream(3'd5, 1'b1, 1'b1);
        check("stall_stopped", 32'(stopped), 1);
        check("stall_handshakes", 32'(stall_hs), 8);
        check("stall_bits", 32'(stall_bits), 32'h3C);
        check("stall_stable", 32'(stall_err), 0);
        check("stall_no_rgo", 32'(stall_rgo), 0);
        check("stall_pixels", 32'(pix_err), 0);
        check("stall_hs_at_stop", 32'(hs), 2600);
        check("stall_busy", 32'(BUSY), 1);
        #2 RESET = 1'b0;
        #1;
        check_idle("reset_async");
        START      = 1'b1;
        SPRITE_SEL = 3'd3;
        PIX_READY  = 1'b1;
        repeat (3) begin
            tick();
            check_idle("reset_start_ignored");
        end
        START = 1'b0;
        RESET = 1'b1;
        tick();
        check_idle("reset_release_idle");

        // Normal fetch after reset.
        start_fetch(3'd3);
        stream(3'd3, 1'b0, 1'b0);
        check("post_reset_handshakes", 32'(hs), 8192);
        check("post_reset_pixels", 32'(pix_err), 0);
        check("post_reset_last", 32'(last_cnt), 1);
        check("post_reset_done_cycle", 32'(done_cyc), 32'(ExpDone));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gameover_sprite_fetch.md
# gameover_sprite_fetch

Read-side sequencer for the game-over sprite ROM. On a start command it walks one 32-row sprite byte by byte, driving the ROM's `SPRITE_ID`/`SPRITE_X`/`SPRITE_Y`/`R_G_O` request lines. It captures each returned 8-pixel byte and serializes it as a 1-bit-per-pixel stream with valid/ready flow control. That stream feeds the frame-buffer writer, which places the game-over screen on the VGA output.

## Interface
- `ROWS`, 32: rows per sprite (1..32); `SPRITE_Y` runs 0..ROWS-1.
- `BYTES_PER_ROW`, 32: bytes per row (1..32); `SPRITE_X` runs 0..BYTES_PER_ROW-1.
- `CLOCK_50`  in  1  sole clock; all logic on its rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `START`  in  1  single-cycle request; sampled only in IDLE.
- `SPRITE_SEL`  in  3  sprite to fetch; latched with `START`.
- `ABORT`  in  1  cancel the fetch in progress; returns to IDLE next cycle, no DONE.
- `R_G_O`  out  1  ROM read enable.
- `SPRITE_ID`  out  3  ROM sprite index.
- `SPRITE_X`  out  5  ROM byte index.
- `SPRITE_Y`  out  5  ROM row index.
- `SPRITE_PIXEL`  in  8  ROM data; valid the cycle after `R_G_O`=1; bit i = column 8·X+i.
- `PIX_VALID`  out  1  stream data valid.
- `PIX_READY`  in  1  downstream accepts when VALID and READY are both 1.
- `PIX_ON`  out  1  pixel value.
- `PIX_COL`  out  8  pixel column, 8·X+i.
- `PIX_ROW`  out  5  pixel row.
- `PIX_LAST`  out  1  high on the final pixel of the sprite.
- `BUSY`  out  1  high from the cycle after START acceptance until DONE.
- `DONE`  out  1  one-cycle pulse after the last pixel handshake.

## Operation
- States: IDLE, REQ, WAIT, SHIFT, FIN.
- IDLE:
  - `START`=1 latches `SPRITE_SEL`, clears X/Y and the bit index, then goes to REQ.
  - `START` is ignored in every other state.
- REQ: `R_G_O`=1, address outputs = latched ID / current X / current Y; go to WAIT.
- WAIT: `R_G_O`=0; capture `SPRITE_PIXEL` into the shift register at cycle end; go to SHIFT.
- SHIFT:
  - `PIX_VALID`=1, `PIX_ON`=shift[0].
  - Each handshake shifts right and increments the bit index.
  - After bit 7: X increments. When X wraps at BYTES_PER_ROW-1, X→0 and Y increments. Then go to REQ.
  - After the final pixel (Y=ROWS-1, X=BYTES_PER_ROW-1, bit 7), go to FIN.
- FIN: `DONE`=1, `BUSY`=0, then IDLE.
- Pixel data and position are stable while `PIX_VALID`=1 and `PIX_READY`=0.
- `ABORT` overrides all states except IDLE. An in-flight ROM response is discarded.
- Reset values:
  - All outputs 0; `SPRITE_ID`/`SPRITE_X`/`SPRITE_Y` = 0.
  - State IDLE; shift register cleared.
- Reset mid-fetch drops the stream immediately. No DONE is issued.

## Timing
- `START` sampled at edge E0.
- Cycle 1: REQ. Cycle 2: WAIT. Cycle 3: first `PIX_VALID`.
- Base build, with `PIX_READY` held at 1: 10 cycles per byte (REQ + WAIT + 8 SHIFT).
  - Defaults: last pixel in cycle 10240, DONE in cycle 10241.
- `R_G_O` is never high for two consecutive cycles in the base build.
- `PIX_READY` low stalls SHIFT only. No ROM request is issued while stalled.

## Configuration
- `GAMEOVER_FETCH_PREFETCH_EN` defined:
  - Adds a one-byte prefetch buffer.
  - While in SHIFT with the buffer empty and bytes remaining, `R_G_O` is pulsed for the next address and the response lands in the buffer one cycle later.
  - On bit 7 handshake, the buffer loads the shift register directly. No REQ/WAIT bubble.
  - With `PIX_READY`=1, pixels are continuous: last pixel in cycle 8194, DONE in cycle 8195.
  - `ABORT`/reset also clear the buffer.
- Macro undefined: base 10-cycle-per-byte behaviour, no buffer logic.

## Test plan
- ROM model: sprite 2, row 0, byte 0 = 0xA5. START with SEL=2, READY=1.
  - Cycle 1: `R_G_O`=1, ID=2, X=0, Y=0.
  - Cycles 3–10: `PIX_ON`=1,0,1,0,0,1,0,1 at `PIX_COL` 0–7, `PIX_ROW` 0.
- Full sprite 7, READY=1, base build:
  - 8192 pixel handshakes.
  - `PIX_LAST` only at COL 255, ROW 31.
  - DONE in cycle 10241; BUSY low from then.
- Same with prefetch defined: DONE in cycle 8195, no gaps in `PIX_VALID`.
- READY toggled 1,0,0,1 on byte 0x3C at row 4, byte 3:
  - Each pixel held stable while stalled; values 0,0,1,1,1,1,0,0 at COL 24–31.
  - No extra `R_G_O` during the stall.
- `ABORT` at pixel 100: idle next cycle with all outputs 0, no DONE. A following START with SEL=1 fetches from Y=0, X=0.
- `RESET` low mid-row 10 while stalled: outputs 0 asynchronously. START ignored while `RESET`=0. After release, a normal fetch completes.
